// File: rtl/pc_seq_pkg.sv
// Shared opcode constants for the program-counter sequencer and its decoder.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      OP_INC  = 3'b000,
      OP_BRC  = 3'b001,
      OP_JMP  = 3'b010,
      OP_CALL = 3'b011,
      OP_RET  = 3'b100,
      OP_HALT = 3'b101
   } op_t;

endpackage

// File: rtl/pc_seq_if.sv
// Decode-to-sequencer bus: control/operands in, PC and status flags out.
interface pc_seq_if #(
   parameter int PC_W  = 8,
   parameter int OFF_W = 4
);
   logic             clr;
   logic             stall;
   logic [2:0]       op;
   logic             cond;
   logic [OFF_W-1:0] offset;
   logic [PC_W-1:0]  target;
   logic [PC_W-1:0]  pc;
   logic             stk_empty;
   logic             stk_full;
   logic             ovf_err;
   logic             unf_err;
   logic             halted;

   modport master (
      output clr, stall, op, cond, offset, target,
      input  pc, stk_empty, stk_full, ovf_err, unf_err, halted
   );

   modport slave (
      input  clr, stall, op, cond, offset, target,
      output pc, stk_empty, stk_full, ovf_err, unf_err, halted
   );
endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: pointer sp in 0..DEPTH, top of stack is entry sp-1.
module pc_ret_stack #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);
   localparam int SP_W  = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);
   localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);

   logic [SP_W-1:0] sp;
   logic [SP_W-1:0] sp_m1;
   logic [W-1:0]    mem [DEPTH];
   logic            do_push;
   logic            do_pop;

   assign sp_m1   = sp - SP_ONE;
   assign empty   = (sp == '0);
   assign full    = (sp == SP_MAX);
   assign do_push = push && !full && !clr;
   assign do_pop  = pop && !empty && !clr;
   assign dout    = mem[sp_m1[IDX_W-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       sp <= '0;
      else if (clr)     sp <= '0;
      else if (do_push) sp <= sp + SP_ONE;
      else if (do_pop)  sp <= sp_m1;
   end

   // NOTE: the entry array has no reset; sp alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[sp[IDX_W-1:0]] <= din;
   end
endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: next-PC mux, relative/absolute branches, CALL/RET
// through a return stack, halt and sticky stack-error flags.
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter int              PC_W      = 8,
   parameter int              OFF_W     = 4,
   parameter int              STK_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_VEC = '0
) (
   input  logic     clk,
   input  logic     rst_n,
   pc_seq_if.slave  bus
);
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] off_sext;
   logic [PC_W-1:0] pc_nxt;
   logic [PC_W-1:0] stk_dout;
   logic            stk_empty;
   logic            stk_full;
   logic            ovf_q, unf_q, halted_q;
   logic            go;
   logic            push, pop, ovf_set, unf_set, halt_set;

   assign go       = !bus.clr && !bus.stall && !halted_q;
   assign pc_inc   = pc_q + PC_W'(1);
   assign off_sext = PC_W'($signed(bus.offset));

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      pc_nxt   = pc_inc;
      push     = 1'b0;
      pop      = 1'b0;
      ovf_set  = 1'b0;
      unf_set  = 1'b0;
      halt_set = 1'b0;
      case (op_t'(bus.op))
         OP_BRC:  if (bus.cond) pc_nxt = pc_q + off_sext;
         OP_JMP:  pc_nxt = bus.target;
         OP_CALL: begin
            if (stk_full) ovf_set = 1'b1;
            else begin
               push   = go;
               pc_nxt = bus.target;
            end
         end
         OP_RET: begin
            if (stk_empty) unf_set = 1'b1;
            else begin
               pop    = go;
               pc_nxt = stk_dout;
            end
         end
         OP_HALT: begin
            halt_set = 1'b1;
            pc_nxt   = pc_q;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_VEC;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         halted_q <= 1'b0;
      end else if (bus.clr) begin
         pc_q     <= RESET_VEC;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         halted_q <= 1'b0;
      end else if (go) begin
         pc_q     <= pc_nxt;
         ovf_q    <= ovf_q | ovf_set;
         unf_q    <= unf_q | unf_set;
         halted_q <= halt_set;
      end
   end

   pc_ret_stack #(.W(PC_W), .DEPTH(STK_DEPTH)) u_stack (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.clr),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .dout  (stk_dout),
      .empty (stk_empty),
      .full  (stk_full)
   );

   assign bus.pc        = pc_q;
   assign bus.stk_empty = stk_empty;
   assign bus.stk_full  = stk_full;
   assign bus.ovf_err   = ovf_q;
   assign bus.unf_err   = unf_q;
   assign bus.halted    = halted_q;
endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq (PC_W=8, OFF_W=4, STK_DEPTH=4, RESET_VEC=0).
module tb_pc_seq;
   import pc_seq_pkg::*;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   pc_seq_if #(.PC_W(8), .OFF_W(4)) bus ();

   pc_seq #(.PC_W(8), .OFF_W(4), .STK_DEPTH(4), .RESET_VEC(8'h00)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one operation for one clock edge, then settle past the edge.
   task automatic step(input logic [2:0] o, input logic c, input logic [3:0] off,
                       input logic [7:0] tgt);
      bus.op     = o;
      bus.cond   = c;
      bus.offset = off;
      bus.target = tgt;
      @(posedge clk);
      #1;
   endtask

   task automatic check_flags(input string tag, input logic emp, input logic ful,
                              input logic ovf, input logic unf, input logic hlt);
      check({tag, ".stk_empty"}, 32'(bus.stk_empty), 32'(emp));
      check({tag, ".stk_full"},  32'(bus.stk_full),  32'(ful));
      check({tag, ".ovf_err"},   32'(bus.ovf_err),   32'(ovf));
      check({tag, ".unf_err"},   32'(bus.unf_err),   32'(unf));
      check({tag, ".halted"},    32'(bus.halted),    32'(hlt));
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      rst_n      = 1'b0;
      bus.clr    = 1'b0;
      bus.stall  = 1'b0;
      bus.op     = OP_INC;
      bus.cond   = 1'b0;
      bus.offset = 4'h0;
      bus.target = 8'h00;

      // 1. reset state, then three increments
      repeat (2) @(posedge clk);
      #1;
      check("rst.pc", 32'(bus.pc), 32'h00);
      check_flags("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(OP_INC, 1'b0, 4'h0, 8'h00); check("inc1", 32'(bus.pc), 32'h01);
      step(OP_INC, 1'b0, 4'h0, 8'h00); check("inc2", 32'(bus.pc), 32'h02);
      step(OP_INC, 1'b0, 4'h0, 8'h00); check("inc3", 32'(bus.pc), 32'h03);

      // 2. relative branches, taken backwards and not taken
      step(OP_JMP, 1'b0, 4'h0, 8'h10); check("jmp10", 32'(bus.pc), 32'h10);
      step(OP_BRC, 1'b1, 4'b1101, 8'h00); check("brc_neg", 32'(bus.pc), 32'h0D);
      step(OP_BRC, 1'b0, 4'b0111, 8'h00); check("brc_nt", 32'(bus.pc), 32'h0E);

      // 3. wrap on increment and on branch in both directions
      step(OP_JMP, 1'b0, 4'h0, 8'hFE); check("jmpFE", 32'(bus.pc), 32'hFE);
      step(OP_INC, 1'b0, 4'h0, 8'h00); check("incFF", 32'(bus.pc), 32'hFF);
      step(OP_INC, 1'b0, 4'h0, 8'h00); check("inc_wrap", 32'(bus.pc), 32'h00);
      step(OP_JMP, 1'b0, 4'h0, 8'h02); check("jmp02", 32'(bus.pc), 32'h02);
      step(OP_BRC, 1'b1, 4'b1101, 8'h00); check("brc_wrap_dn", 32'(bus.pc), 32'hFF);
      step(OP_BRC, 1'b1, 4'b0111, 8'h00); check("brc_wrap_up", 32'(bus.pc), 32'h06);

      // 4. nested call/return
      step(OP_JMP, 1'b0, 4'h0, 8'h20);
      step(OP_CALL, 1'b0, 4'h0, 8'h40); check("call40", 32'(bus.pc), 32'h40);
      check("call40.empty", 32'(bus.stk_empty), 32'h0);
      step(OP_CALL, 1'b0, 4'h0, 8'h60); check("call60", 32'(bus.pc), 32'h60);
      step(OP_RET, 1'b0, 4'h0, 8'h00); check("ret41", 32'(bus.pc), 32'h41);
      step(OP_RET, 1'b0, 4'h0, 8'h00); check("ret21", 32'(bus.pc), 32'h21);
      check("ret21.empty", 32'(bus.stk_empty), 32'h1);

      // 5. overflow and underflow
      step(OP_JMP, 1'b0, 4'h0, 8'h00);
      for (int i = 0; i < 4; i++) step(OP_CALL, 1'b0, 4'h0, 8'h80);
      check("fill.pc", 32'(bus.pc), 32'h80);
      check_flags("fill", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(OP_CALL, 1'b0, 4'h0, 8'h80); check("ovf.pc", 32'(bus.pc), 32'h81);
      check_flags("ovf", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(OP_RET, 1'b0, 4'h0, 8'h00); check("pop1", 32'(bus.pc), 32'h81);
      step(OP_RET, 1'b0, 4'h0, 8'h00); check("pop2", 32'(bus.pc), 32'h81);
      step(OP_RET, 1'b0, 4'h0, 8'h00); check("pop3", 32'(bus.pc), 32'h81);
      step(OP_RET, 1'b0, 4'h0, 8'h00); check("pop4", 32'(bus.pc), 32'h01);
      step(OP_RET, 1'b0, 4'h0, 8'h00); check("unf.pc", 32'(bus.pc), 32'h02);
      check_flags("unf", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(OP_CALL, 1'b0, 4'h0, 8'h30); check("call_after_err", 32'(bus.pc), 32'h30);
      step(OP_RET, 1'b0, 4'h0, 8'h00); check("ret_after_err", 32'(bus.pc), 32'h03);
      check_flags("sticky", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(3'b110, 1'b0, 4'h0, 8'h00); check("rsv110", 32'(bus.pc), 32'h04);
      step(3'b111, 1'b0, 4'h0, 8'h00); check("rsv111", 32'(bus.pc), 32'h05);

      // 6. halt, clr, stall, async reset
      step(OP_HALT, 1'b0, 4'h0, 8'h00); check("halt.pc", 32'(bus.pc), 32'h05);
      check("halt.flag", 32'(bus.halted), 32'h1);
      for (int i = 0; i < 5; i++) step(OP_INC, 1'b0, 4'h0, 8'h00);
      check("halt_hold.pc", 32'(bus.pc), 32'h05);
      step(OP_CALL, 1'b0, 4'h0, 8'h70); check("halt_call.pc", 32'(bus.pc), 32'h05);
      check("halt_call.empty", 32'(bus.stk_empty), 32'h1);
      bus.clr = 1'b1;
      step(OP_INC, 1'b0, 4'h0, 8'h00); check("clr.pc", 32'(bus.pc), 32'h00);
      check_flags("clr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.clr = 1'b0;
      step(OP_CALL, 1'b0, 4'h0, 8'h50); check("call50", 32'(bus.pc), 32'h50);
      bus.stall = 1'b1;
      step(OP_CALL, 1'b0, 4'h0, 8'h70); check("stall.pc", 32'(bus.pc), 32'h50);
      check_flags("stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.stall = 1'b0;
      step(OP_RET, 1'b0, 4'h0, 8'h00); check("stall_ret", 32'(bus.pc), 32'h01);
      step(OP_CALL, 1'b0, 4'h0, 8'h50); check("call50b", 32'(bus.pc), 32'h50);
      bus.clr   = 1'b1;
      bus.stall = 1'b1;
      step(OP_INC, 1'b0, 4'h0, 8'h00); check("clr_over_stall", 32'(bus.pc), 32'h00);
      check("clr_over_stall.empty", 32'(bus.stk_empty), 32'h1);
      bus.clr   = 1'b0;
      bus.stall = 1'b0;

      step(OP_RET, 1'b0, 4'h0, 8'h00);
      step(OP_JMP, 1'b0, 4'h0, 8'h10);
      step(OP_CALL, 1'b0, 4'h0, 8'h40);
      step(OP_CALL, 1'b0, 4'h0, 8'h60); check("chain.pc", 32'(bus.pc), 32'h60);
      check_flags("chain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst.pc", 32'(bus.pc), 32'h00);
      check_flags("arst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(OP_INC, 1'b0, 4'h0, 8'h00); check("post_rst.inc", 32'(bus.pc), 32'h01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
